// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the RISC-V test-completion monitor: FSM state
// encodings and the default register indices that carry test status.
package riscv_test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_e;

  localparam int DEF_TESTNUM_REG = 3;   // x3 (gp): current test number
  localparam int DEF_DONE_REG    = 26;  // x26: written with 1 at test end
  localparam int DEF_RESULT_REG  = 27;  // x27: 1 = pass

endpackage

// File: rtl/reg_snoop.sv
// Single-register shadow of a register-file write-back port. q_next is the
// value the shadow takes on the coming edge, so the owner can latch a
// verdict that includes a write accepted on that same edge.
module reg_snoop
  import riscv_test_monitor_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IDX        = DEF_DONE_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q_next
);

  logic [DATA_W-1:0] q;
  logic              hit;

  // Next shadow value: clear wins, then an enabled write to our index (x0 never matches)
  always_comb begin
    hit    = en && we && (waddr == REG_ADDR_W'(IDX)) && (waddr != '0);
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (hit) begin
      q_next = wdata;
    end
  end

  // Shadow register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Test-completion monitor: snoops write-back, waits a settle interval after
// the done register is written with 1, then latches a pass/fail verdict.
// Includes a saturating cycle counter and a RUN-state watchdog.
// Optional macro TEST_MONITOR_DISPLAY_EN adds a simulation-only verdict banner.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int DONE_REG       = DEF_DONE_REG,
  parameter int RESULT_REG     = DEF_RESULT_REG,
  parameter int TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int SETTLE_CYCLES  = 20,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [DATA_W-1:0]     testnum_o,
  output logic [CNT_W-1:0]      cycles_o
);

  localparam int             SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam bit             WD_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_state_e        state;
  logic [SC_W-1:0]   settle_cnt;
  logic              active, arm;
  logic              done_wr, done_hit, settle_end, go_timeout, go_done, pass_now;
  logic [DATA_W-1:0] done_next, result_next, testnum_next;

  reg_snoop #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .IDX(DONE_REG)) u_done (
    .clk(clk), .rst(rst), .clr(arm), .en(active), .we(we_i),
    .waddr(waddr_i), .wdata(wdata_i), .q_next(done_next)
  );

  reg_snoop #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .IDX(RESULT_REG)) u_result (
    .clk(clk), .rst(rst), .clr(arm), .en(active), .we(we_i),
    .waddr(waddr_i), .wdata(wdata_i), .q_next(result_next)
  );

  reg_snoop #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .IDX(TESTNUM_REG)) u_testnum (
    .clk(clk), .rst(rst), .clr(arm), .en(active), .we(we_i),
    .waddr(waddr_i), .wdata(wdata_i), .q_next(testnum_next)
  );

  // Transition conditions; a done write on the watchdog's last cycle wins over the timeout
  always_comb begin
    active     = (state == ST_RUN) || (state == ST_SETTLE);
    arm        = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    done_wr    = we_i && (waddr_i == REG_ADDR_W'(DONE_REG)) && (waddr_i != '0);
    done_hit   = (state == ST_RUN) && done_wr && (done_next == DATA_W'(1));
    settle_end = (state == ST_SETTLE) && (settle_cnt == '0);
    go_timeout = WD_EN && (state == ST_RUN) && (cycles_o == TO_LAST) && !done_hit;
    go_done    = (done_hit && (SETTLE_CYCLES == 0)) || settle_end || go_timeout;
    pass_now   = !go_timeout && (result_next == DATA_W'(1));
  end

  // Monitor FSM with settle counter, cycle counter and registered verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      testnum_o  <= '0;
      cycles_o   <= '0;
    end else if (arm) begin
      state      <= ST_RUN;
      settle_cnt <= '0;
      busy_o     <= 1'b1;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      testnum_o  <= '0;
      cycles_o   <= '0;
    end else if (go_done) begin
      // cycles_o is not advanced on the edge that enters DONE
      state     <= ST_DONE;
      busy_o    <= 1'b0;
      done_o    <= 1'b1;
      pass_o    <= pass_now;
      fail_o    <= !pass_now;
      timeout_o <= go_timeout;
      testnum_o <= testnum_next;
    end else if (active) begin
      if (cycles_o != '1) begin
        cycles_o <= cycles_o + CNT_W'(1);
      end
      if (done_hit) begin
        state      <= ST_SETTLE;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt - SC_W'(1);
      end
    end
  end

`ifdef TEST_MONITOR_DISPLAY_EN
  // Verdict banner on entry to DONE (simulation only)
  always @(posedge done_o) begin
    if (pass_o) begin
      $display("[riscv_test_monitor] *** PASS ***");
    end else begin
      $display("[riscv_test_monitor] *** TEST FAILED *** test %0d after %0d cycles%s",
               testnum_o, cycles_o, timeout_o ? " (timeout)" : "");
    end
  end
`endif

endmodule
